// File: rtl/an_code_pkg.sv
// Shared AN-code constants and FSM state type for the AN encoder and the SEC decoder.
// A must be odd and below 2**A_BITS; W_BITS leaves one bit of overflow margin above N_BITS+A_BITS.
package an_code_pkg;

    localparam int A      = 131;
    localparam int A_BITS = 8;
    localparam int N_BITS = 52;
    localparam int W_BITS = 61;
    localparam int CNT_W  = $clog2(A_BITS);

    localparam logic [A_BITS-1:0] A_VEC = A_BITS'(A);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/an_encoder_52bits_clk.sv
// AN-code encoder: W = A*N by serial shift-add, one bit of A per cycle, one operand in flight.
// Optional macro AWE_INJECT_EN adds err_en/err_sign/err_pos to inject a +/-2**pos arithmetic error into W.
module an_encoder_52bits_clk
    import an_code_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] N,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_BITS-1:0] W
`ifdef AWE_INJECT_EN
    ,
    input  logic              err_en,
    input  logic              err_sign,
    input  logic [5:0]        err_pos
`endif
);

    state_t              r_state;
    state_t              w_state_next;
    logic [W_BITS-1:0]   r_n_ext;
    logic [W_BITS-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [W_BITS-1:0]   r_w;
    logic [W_BITS-1:0]   w_addend;
    logic [W_BITS-1:0]   w_sum;
    logic [W_BITS-1:0]   w_final;
    logic                w_last;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign W         = r_w;

    assign w_last   = (r_cnt == CNT_W'(A_BITS - 1));
    assign w_addend = A_VEC[r_cnt] ? (r_n_ext << r_cnt) : '0;
    assign w_sum    = r_acc + w_addend;

`ifdef AWE_INJECT_EN
    localparam logic [5:0] W_BITS_POS = 6'(W_BITS);

    logic              r_err_en;
    logic              r_err_sign;
    logic [5:0]        r_err_pos;
    logic [W_BITS-1:0] w_delta;

    // Positions beyond the codeword width inject nothing rather than aliasing.
    assign w_delta = (r_err_en && (r_err_pos < W_BITS_POS)) ? (W_BITS'(1) << r_err_pos) : '0;
    assign w_final = r_err_sign ? (w_sum - w_delta) : (w_sum + w_delta);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_en   <= 1'b0;
            r_err_sign <= 1'b0;
            r_err_pos  <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_err_en   <= err_en;
            r_err_sign <= err_sign;
            r_err_pos  <= err_pos;
        end
    end
`else
    assign w_final = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = MUL;
            MUL:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n_ext <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_w     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_n_ext <= W_BITS'(N);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                MUL: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_w <= w_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
